// File: rtl/ula_pkg.sv
// ula_pkg: ULActl operation codes and sequencer state shared by ulacontrol, the ULA and ula_muldiv_seq.
package ula_pkg;
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SRL = 4'b0011;
  localparam logic [3:0] ULA_MUL = 4'b0100;
  localparam logic [3:0] ULA_DIV = 4'b0101;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_LUI = 4'b1000;
  localparam logic [3:0] ULA_REM = 4'b1001;
  localparam logic [3:0] ULA_NOT = 4'b1100;
  localparam logic [3:0] ULA_SLL = 4'b1110;
  localparam logic [3:0] ULA_INV = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return op == ULA_MUL || op == ULA_DIV || op == ULA_REM;
  endfunction
endpackage

// File: rtl/ula_divstep.sv
// ula_divstep: one combinational restoring-division step on unsigned magnitudes.
module ula_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  // rem_in < divisor always holds, so the restored remainder fits in WIDTH bits
  assign trial   = {rem_in, bit_in};
  assign diff    = {1'b0, trial} - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/ula_muldiv_seq.sv
// ula_muldiv_seq: iterative mul/div/rem sequencer that stalls the pipeline until the result is ready.
module ula_muldiv_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ULActl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divzero
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [3:0]       op;
  logic             sa, sb;
  logic [WIDTH-1:0] ma, mb, acc, q, step_rem;
  logic             step_q, accept, bzero;

  assign accept = start && state == IDLE && is_iter(ULActl);
  assign bzero  = B == '0 && ULActl != ULA_MUL;

  ula_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc),
    .divisor (mb),
    .bit_in  (q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = accept ? (bzero ? DONE : CALC) : IDLE;
      CALC: state_nx = count == CW'(WIDTH - 1) ? FIX : CALC;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall = accept || state == CALC || state == FIX;
    done  = state == DONE;
  end

  // q holds the multiplier (mul) or the dividend shifting out / quotient shifting in (div, rem)
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count   <= '0;
      op      <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      acc     <= '0;
      q       <= '0;
      result  <= '0;
      divzero <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      op      <= ULActl;
      sa      <= A[WIDTH-1];
      sb      <= B[WIDTH-1];
      ma      <= A[WIDTH-1] ? -A : A;
      mb      <= B[WIDTH-1] ? -B : B;
      acc     <= '0;
      q       <= ULActl == ULA_MUL ? (B[WIDTH-1] ? -B : B) : (A[WIDTH-1] ? -A : A);
      divzero <= bzero;
      if (bzero) result <= ULActl == ULA_DIV ? '1 : A;
    end else if (state == CALC) begin
      count <= count + 1'b1;
      acc   <= op == ULA_MUL ? (acc << 1) + (q[WIDTH-1] ? ma : '0) : step_rem;
      q     <= {q[WIDTH-2:0], op == ULA_MUL ? 1'b0 : step_q};
    end else if (state == FIX) begin
      result <= op == ULA_MUL ? ((sa ^ sb) ? -acc : acc) :
                op == ULA_DIV ? ((sa ^ sb) ? -q : q) :
                (sa ? -acc : acc);
    end
endmodule

// File: doc/ula_muldiv_seq.md
# ula_muldiv_seq

Multi-cycle sequencer for the ULA's iterative operations: mul (ULActl 4'b0100), div (4'b0101) and rem (4'b1001). It sits beside the single-cycle ULA in the execute stage and accepts an operation when the ULActl code is one of these three. It computes the result by shift-add or restoring division and holds the processor in stall until the result is ready. All other ULActl codes are ignored and remain the single-cycle ULA's job.

## Interface
- WIDTH, 32, operand/result width.
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  operation request, sampled each clock.
- ULActl  in  4  operation code from ulacontrol.
- A  in  WIDTH  signed operand 1 (multiplicand / dividend).
- B  in  WIDTH  signed operand 2 (multiplier / divisor).
- stall  out  1  processor freeze request.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  product low half, quotient or remainder.
- divzero  out  1  valid with done; set for div/rem with B==0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept:
  - Condition: start=1, state IDLE, ULActl in {0100, 0101, 1001}.
  - Latch op, sign(A), sign(B), |A|, |B|.
  - Clear partial product/remainder; count=0.
- No accept (stay IDLE):
  - start with any other code.
  - start while not IDLE.
- IDLE→DONE directly when accept is a div/rem with B==0.
  - div: result=all ones. rem: result=A. divzero=1.
- IDLE→CALC on any other accept.
- CALC, one bit per cycle, WIDTH cycles:
  - mul: shift-add on magnitudes; keep low WIDTH bits.
  - div/rem: restoring step on magnitudes, MSB first.
  - count increments each cycle; at count==WIDTH-1 go to FIX.
- FIX, one cycle, sign correction:
  - mul: negate if sign(A)^sign(B).
  - div: negate quotient if sign(A)^sign(B).
  - rem: negate remainder if sign(A); remainder sign follows dividend.
- DONE, one cycle: done=1, result valid, then →IDLE.
- Overflow case A=0x80000000, B=-1, div: quotient 0x80000000, rem 0, divzero=0. This must fall out of the magnitude path with no special case.
- result and divzero hold their value after DONE until the next accept.
- Reset, asynchronous, effective at any state including mid-CALC: state=IDLE, count=0, result=0, divzero=0, done=0, stall=0. Any operation in progress is discarded.

## Timing
- Accept sampled at edge N.
- stall is combinational: high in cycle N when the accept condition holds, and high in every cycle the state is CALC or FIX. The pipeline freezes in the same cycle the request appears.
- Normal op:
  - CALC occupies cycles N+1..N+WIDTH.
  - FIX occupies cycle N+WIDTH+1.
  - done=1, stall=0 in cycle N+WIDTH+2 (N+34 for WIDTH=32).
  - Total latency: WIDTH+2 cycles from accept to done.
- Divide by zero: done in cycle N+1; stall high only in cycle N.
- During DONE stall=0, so the pipeline advances and captures result on that edge.
- start=1 with a valid code in DONE is ignored. A new accept is possible from the following IDLE cycle.
- Back-to-back ops: minimum spacing WIDTH+3 cycles between accepts.

## Structure
- Shared package ula_pkg:
  - ULActl code constants: ULA_AND 0000, ULA_OR 0001, ULA_ADD 0010, ULA_SRL 0011, ULA_MUL 0100, ULA_DIV 0101, ULA_SUB 0110, ULA_SLT 0111, ULA_LUI 1000, ULA_REM 1001, ULA_NOT 1100, ULA_SLL 1110, ULA_INV 1111.
  - State enum: IDLE, CALC, FIX, DONE.
  - These constants are shared with ulacontrol and the ULA.
- Counter width: $clog2(WIDTH).
- One sub-module, ula_divstep: combinational single restoring-division step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder, quotient bit. Instantiated once and used every CALC cycle.

## Test plan
- mul, A=7, B=-6: stall high cycles N..N+33; done at N+34; result=0xFFFFFFD6 (-42); divzero=0.
- div A=-7, B=2 → result=0xFFFFFFFD (-3). rem A=-7, B=2 → result=0xFFFFFFFF (-1). Both done at N+34.
- div A=5, B=0: done at N+1, result=0xFFFFFFFF, divzero=1. rem A=5, B=0: result=5, divzero=1.
- div A=0x80000000, B=0xFFFFFFFF: result=0x80000000, divzero=0. Then rem with the same operands: result=0.
- start with ULActl=0010 (add): no stall, no done; state stays IDLE. start with ULActl=0100 pulsed again at N+10 while busy: ignored, single done at N+34.
- reset asserted at N+15 mid-mul: stall, done, result, divzero go to 0 immediately. After release, a new mul A=3, B=4 completes with result=12 at latency WIDTH+2.
